// File: rtl/iter_linear_cal_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iter_linear_cal_multi
// Purpose  : Multi-channel y = m*x + b calibrator built on one shared
//            shift-add multiplier that retires one multiplier bit per clock.
//            Per-channel gain/offset bank, optional saturating output.
// Revision : 1.0 - initial release
// ============================================================================
module iter_linear_cal_multi #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic             cfg_sel,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             wr,
  input  logic [CHW-1:0]   ch,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic [WIDTH-1:0] y,
  output logic [CHW-1:0]   y_ch,
  output logic             valid,
  output logic             sat,
  output logic             drop
);

  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q [NCH];
  logic [WIDTH-1:0]     m_d [NCH];
  logic [WIDTH-1:0]     b_q [NCH];
  logic [WIDTH-1:0]     b_d [NCH];
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     boff_q, boff_d;
  logic [CHW-1:0]       tag_q, tag_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [CHW-1:0]       y_ch_q, y_ch_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic                 drop_q, drop_d;

  // Channel indices are widened before the range test so the test stays a
  // real comparison even when NCH fills the whole index space.
  logic [31:0]          ch_ext, cfg_ch_ext;
  logic                 ch_ok, cfg_ok;
  logic [WIDTH-1:0]     sel_m, sel_b;
  logic [2*WIDTH:0]     sum;
  logic                 sum_ovf;

  assign ch_ext     = 32'(ch);
  assign cfg_ch_ext = 32'(cfg_ch);
  assign ch_ok      = (ch_ext < 32'(NCH));
  assign cfg_ok     = (cfg_ch_ext < 32'(NCH));

  // Final offset add, one bit wider than the product so the carry is kept.
  assign sum     = {1'b0, acc_q} + {{(WIDTH + 1){1'b0}}, boff_q};
  assign sum_ovf = |sum[2*WIDTH:WIDTH];

  // Coefficient read mux for the channel presented with the sample.
  always_comb begin
    sel_m = '0;
    sel_b = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == CHW'(i)) begin
        sel_m = m_q[i];
        sel_b = b_q[i];
      end
    end
  end

  // Coefficient bank update; out-of-range channels are silently ignored.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      m_d[i] = m_q[i];
      b_d[i] = b_q[i];
      if (cfg_wr && cfg_ok && (cfg_ch == CHW'(i))) begin
        if (cfg_sel) b_d[i] = cfg_data;
        else         m_d[i] = cfg_data;
      end
    end
  end

  // Sequencer: accept, iterate WIDTH multiplier bits, add offset, publish.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    boff_d   = boff_q;
    tag_d    = tag_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    y_d      = y_q;
    y_ch_d   = y_ch_q;
    sat_d    = sat_q;
    valid_d  = 1'b0;
    drop_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr) begin
          if (ch_ok) begin
            // Operands are captured here, so later cfg writes cannot disturb them.
            mcand_d  = {{WIDTH{1'b0}}, x};
            mplier_d = sel_m;
            boff_d   = sel_b;
            tag_d    = ch;
            acc_d    = '0;
            cnt_d    = CNTW'(WIDTH);
            busy_d   = 1'b1;
            state_d  = S_MULT;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_MULT: begin
        drop_d = wr;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = S_ADD;
      end
      S_ADD: begin
        drop_d  = wr;
        res_d   = (SAT && sum_ovf) ? '1 : sum[WIDTH-1:0];
        ovf_d   = sum_ovf;
        state_d = S_DONE;
      end
      S_DONE: begin
        drop_d  = wr;
        y_d     = res_q;
        y_ch_d  = tag_q;
        sat_d   = ovf_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and coefficient registers; reset aborts any computation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < NCH; i++) begin
        m_q[i] <= WIDTH'(1);
        b_q[i] <= '0;
      end
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      boff_q   <= '0;
      tag_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      y_q      <= '0;
      y_ch_q   <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      for (int i = 0; i < NCH; i++) begin
        m_q[i] <= m_d[i];
        b_q[i] <= b_d[i];
      end
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      boff_q   <= boff_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      y_q      <= y_d;
      y_ch_q   <= y_ch_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
      drop_q   <= drop_d;
    end
  end

  assign busy  = busy_q;
  assign y     = y_q;
  assign y_ch  = y_ch_q;
  assign valid = valid_q;
  assign sat   = sat_q;
  assign drop  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_linear_cal_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_iter_linear_cal_multi
// Purpose  : Bench for iter_linear_cal_multi. Two instances share stimulus:
//            A = 4 channels, saturating; B = 3 channels, wrapping. A
//            transaction-level model predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_linear_cal_multi;

  localparam int W   = 32;
  localparam int LAT = W + 2;   // accept edge to valid edge
  localparam int THR = W + 3;   // accept edge to next possible accept edge

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic             cfg_sel = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [W-1:0]     cfg_data = '0;
  logic             wr = 1'b0;
  logic [1:0]       ch = '0;
  logic [W-1:0]     x = '0;

  logic [1:0]          busy_o, valid_o, sat_o, drop_o;
  logic [1:0][W-1:0]   y_o;
  logic [1:0][1:0]     ych_o;

  iter_linear_cal_multi #(.WIDTH(W), .NCH(4), .CHW(2), .SAT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch),
    .cfg_data(cfg_data), .wr(wr), .ch(ch), .x(x), .busy(busy_o[0]), .y(y_o[0]),
    .y_ch(ych_o[0]), .valid(valid_o[0]), .sat(sat_o[0]), .drop(drop_o[0])
  );

  iter_linear_cal_multi #(.WIDTH(W), .NCH(3), .CHW(2), .SAT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch),
    .cfg_data(cfg_data), .wr(wr), .ch(ch), .x(x), .busy(busy_o[1]), .y(y_o[1]),
    .y_ch(ych_o[1]), .valid(valid_o[1]), .sat(sat_o[1]), .drop(drop_o[1])
  );

  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] mdl_m [2][4];
  logic [W-1:0] mdl_b [2][4];
  longint       ecnt = 0;
  longint       free_at [2];
  longint       pend_due [2];
  bit           pend [2];
  logic [W-1:0] pend_y [2];
  logic [1:0]   pend_ch [2];
  bit           pend_sat [2];
  bit           exp_busy [2], exp_valid [2], exp_drop [2], exp_sat [2];
  logic [W-1:0] exp_y [2];
  logic [1:0]   exp_ych [2];

  int busy_cycles = 0;
  int valid_cycles = 0;

  function automatic int nch_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic bit sat_of(input int k);
    return (k == 0);
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 4; i++) begin
      mdl_m[k][i] = 1;
      mdl_b[k][i] = 0;
    end
    free_at[k] = 0; pend[k] = 0; pend_due[k] = 0;
    exp_busy[k] = 0; exp_valid[k] = 0; exp_drop[k] = 0; exp_sat[k] = 0;
    exp_y[k] = '0; exp_ych[k] = '0;
  endtask

  // Predicts the effect of the coming rising edge from the current inputs.
  task automatic model_edge();
    logic [63:0] full;
    ecnt++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_reset(k);
      end else begin
        exp_valid[k] = 0;
        exp_drop[k]  = 0;
        if (pend[k] && ecnt == pend_due[k]) begin
          exp_valid[k] = 1;
          exp_y[k]     = pend_y[k];
          exp_ych[k]   = pend_ch[k];
          exp_sat[k]   = pend_sat[k];
          pend[k]      = 0;
        end
        if (wr) begin
          if (ecnt >= free_at[k] && int'(ch) < nch_of(k)) begin
            full = 64'(mdl_m[k][ch]) * 64'(x) + 64'(mdl_b[k][ch]);
            pend_sat[k] = (full > 64'h0000_0000_FFFF_FFFF);
            pend_y[k]   = (pend_sat[k] && sat_of(k)) ? 32'hFFFF_FFFF : full[31:0];
            pend_ch[k]  = ch;
            pend[k]     = 1;
            pend_due[k] = ecnt + LAT;
            free_at[k]  = ecnt + THR;
          end else begin
            exp_drop[k] = 1;
          end
        end
        if (cfg_wr && int'(cfg_ch) < nch_of(k)) begin
          if (cfg_sel) mdl_b[k][cfg_ch] = cfg_data;
          else         mdl_m[k][cfg_ch] = cfg_data;
        end
        exp_busy[k] = (ecnt + 1 < free_at[k]);
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("busy[%0d]", k),  64'(busy_o[k]),  64'(exp_busy[k]));
      check_eq($sformatf("valid[%0d]", k), 64'(valid_o[k]), 64'(exp_valid[k]));
      check_eq($sformatf("drop[%0d]", k),  64'(drop_o[k]),  64'(exp_drop[k]));
      check_eq($sformatf("y[%0d]", k),     64'(y_o[k]),     64'(exp_y[k]));
      check_eq($sformatf("y_ch[%0d]", k),  64'(ych_o[k]),   64'(exp_ych[k]));
      check_eq($sformatf("sat[%0d]", k),   64'(sat_o[k]),   64'(exp_sat[k]));
    end
  endtask

  // One clock: predict, let the edge happen, compare mid-cycle, clear strobes.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    if (busy_o[0])  busy_cycles++;
    if (valid_o[0]) valid_cycles++;
    wr = 1'b0;
    cfg_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input logic [1:0] c, input logic s, input logic [W-1:0] d);
    cfg_wr = 1'b1; cfg_ch = c; cfg_sel = s; cfg_data = d;
    step();
  endtask

  task automatic sample(input logic [1:0] c, input logic [W-1:0] v);
    wr = 1'b1; ch = c; x = v;
    step();
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 4))
      0:       return W'($urandom_range(0, 255));
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(1) << $urandom_range(0, 31);
      default: return W'($urandom());
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    idle(2);                 // reset held: outputs must sit at reset values
    rst = 1'b0;
    idle(2);

    // Reset defaults: identity coefficients
    sample(0, 16);
    idle(40);
    check_eq("dflt_y_a", 64'(y_o[0]), 64'd16);
    check_eq("dflt_y_b", 64'(y_o[1]), 64'd16);

    // Basic calibration with busy/valid width measurement
    cfg(1, 0, 11);
    cfg(1, 1, 10);
    busy_cycles = 0; valid_cycles = 0;
    sample(1, 16);
    idle(40);
    check_eq("basic1_y", 64'(y_o[0]), 64'd186);
    check_eq("basic1_ch", 64'(ych_o[0]), 64'd1);
    check_eq("busy_width", 64'(busy_cycles), 64'd34);
    check_eq("valid_width", 64'(valid_cycles), 64'd1);
    cfg(2, 0, 7);
    cfg(2, 1, 10);
    sample(2, 12);
    idle(40);
    check_eq("basic2_y", 64'(y_o[0]), 64'd94);
    check_eq("basic2_ch", 64'(ych_o[1]), 64'd2);

    // Overflow: A saturates, B wraps
    cfg(0, 0, 32'h0001_0000);
    cfg(0, 1, 5);
    sample(0, 32'h0001_0000);
    idle(40);
    check_eq("ovf1_y_sat", 64'(y_o[0]), 64'hFFFF_FFFF);
    check_eq("ovf1_y_wrap", 64'(y_o[1]), 64'd5);
    check_eq("ovf1_flag_b", 64'(sat_o[1]), 64'd1);
    cfg(0, 0, 32'hFFFF_FFFF);
    cfg(0, 1, 1);
    sample(0, 1);
    idle(40);
    check_eq("ovf2_y_sat", 64'(y_o[0]), 64'hFFFF_FFFF);
    check_eq("ovf2_y_wrap", 64'(y_o[1]), 64'd0);

    // Busy collisions: extra wr dropped, cfg during MULT only hits next sample
    cfg(1, 0, 3);
    sample(1, 5);
    idle(5);
    sample(2, 1);
    cfg(1, 0, 4);
    idle(40);
    check_eq("coll_old_m", 64'(y_o[0]), 64'd25);
    sample(1, 5);
    idle(40);
    check_eq("coll_new_m", 64'(y_o[0]), 64'd30);

    // Same-edge sample and cfg on the same channel: old gain applies
    wr = 1'b1; ch = 2; x = 3;
    cfg_wr = 1'b1; cfg_ch = 2; cfg_sel = 1'b0; cfg_data = 100;
    step();
    idle(40);
    check_eq("same_edge_old", 64'(y_o[0]), 64'd31);
    sample(2, 3);
    idle(40);
    check_eq("same_edge_new", 64'(y_o[0]), 64'd310);

    // Channel 3: valid on A, dropped on B; cfg to ch3 leaves B untouched
    sample(3, 7);
    cfg(3, 0, 99);
    idle(40);
    sample(3, 2);
    idle(40);
    check_eq("ch3_a_y", 64'(y_o[0]), 64'd198);

    // Reset mid-operation: no valid, coefficients back to identity
    sample(1, 5);
    idle(9);
    rst = 1'b1;
    valid_cycles = 0;
    step();
    rst = 1'b0;
    idle(40);
    check_eq("rst_no_valid", 64'(valid_cycles), 64'd0);
    sample(1, 9);
    idle(40);
    check_eq("rst_ident_a", 64'(y_o[0]), 64'd9);
    check_eq("rst_ident_b", 64'(y_o[1]), 64'd9);

    // Randomized traffic, all checked against the model every cycle
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        wr = 1'b1; ch = 2'($urandom_range(0, 3)); x = rand_val();
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg_wr = 1'b1; cfg_ch = 2'($urandom_range(0, 3));
        cfg_sel = 1'($urandom_range(0, 1)); cfg_data = rand_val();
      end
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iter_linear_cal_multi.md
# iter_linear_cal_multi

Multi-channel, parametrised successor to the single-channel iterative linear calibrator. It computes y = m·x + b with a shift-add multiplier that retires one multiplier bit per clock. Each channel has its own gain (m) and offset (b) register, and an optional saturating output mode is provided. It sits between the ADC sample stream and downstream processing, trading latency for area: one multiplier datapath is shared by all channels.

## Interface
Parameters:
- WIDTH, 32, width of x, m, b, y (unsigned).
- NCH, 4, number of channels (≥1).
- CHW, 2, channel index width; must satisfy 2^CHW ≥ NCH.
- SAT, 1, 1 = saturate y at 2^WIDTH−1; 0 = wrap (truncate to WIDTH LSBs).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_wr  in  1  coefficient write strobe, one cycle.
- cfg_sel  in  1  0 = write m, 1 = write b.
- cfg_ch  in  CHW  channel addressed by cfg_wr.
- cfg_data  in  WIDTH  coefficient value.
- wr  in  1  sample strobe, one cycle.
- ch  in  CHW  channel of sample x.
- x  in  WIDTH  sample value.
- busy  out  1  high while a computation is in flight.
- y  out  WIDTH  result; held until the next result.
- y_ch  out  CHW  channel tag of y.
- valid  out  1  one-cycle pulse when y/y_ch update.
- sat  out  1  sampled with valid; 1 = the result exceeded WIDTH bits (clamped if SAT=1, wrapped if SAT=0).
- drop  out  1  one-cycle pulse when wr is ignored.

## Operation
- Coefficient bank: NCH × {m, b}.
  - Reset values: m=1, b=0 (identity).
  - cfg_wr writes on the clock edge.
  - cfg_ch ≥ NCH: write ignored.
  - cfg writes are legal at any time. They never affect an in-flight computation, because operands are latched at acceptance.
- FSM states: IDLE → MULT → ADD → DONE → IDLE.
  - IDLE: wr=1 with ch<NCH is accepted. Latch x, ch, m[ch] and b[ch]. Clear the 2·WIDTH accumulator and load the iteration counter with WIDTH. Go to MULT.
  - IDLE: wr=1 with ch ≥ NCH pulses drop and stays in IDLE.
  - MULT, each cycle: if multiplier LSB=1, acc += multiplicand. Then shift the multiplicand left and the multiplier right, and decrement the counter. Leave after exactly WIDTH cycles. There is no early termination, so latency is constant.
  - ADD: sum = acc + zero-extended b, computed at 2·WIDTH+1 bits.
    - ovf = (sum ≥ 2^WIDTH).
    - y_next = SAT ? (ovf ? all-ones : sum[WIDTH-1:0]) : sum[WIDTH-1:0].
  - DONE: register y, y_ch and sat=ovf; pulse valid. Return to IDLE.
- wr while busy: ignored, drop pulses, in-flight operation unaffected.
- wr and cfg_wr on the same edge for the same channel: the sample uses the old coefficient; the new value applies from the next sample.
- Reset values of all outputs: busy=0, y=0, y_ch=0, valid=0, sat=0, drop=0; FSM in IDLE.
- Reset asserted mid-operation aborts the computation. No valid is produced, and coefficients return to m=1, b=0.

## Timing
- Acceptance edge T0: wr sampled high in IDLE.
- busy: high from T0+1 through the DONE cycle inclusive, low again at T0+WIDTH+3. The earliest next accepted wr is at edge T0+WIDTH+3.
- MULT occupies cycles T0+1 … T0+WIDTH, ADD is T0+WIDTH+1, DONE is T0+WIDTH+2.
- valid is high for exactly the one cycle following edge T0+WIDTH+2. Latency is WIDTH+2 clocks, which is 34 for WIDTH=32.
- drop is high for the one cycle following the edge that saw the ignored wr.
- Throughput: one result per WIDTH+3 clocks.

## Test plan
- Reset defaults: release rst, then wr ch=0, x=16 → valid after 34 clocks, y=16, y_ch=0, sat=0.
- Basic calibration: cfg ch1 m=11, b=10; wr ch=1, x=16 → y=186, y_ch=1. Then cfg ch2 m=7, b=10; wr ch=2, x=12 → y=94, y_ch=2. Check busy width = 34 cycles and valid width = 1.
- Overflow: WIDTH=32, m=0x0001_0000, b=5, x=0x0001_0000.
  - SAT=1 → y=0xFFFF_FFFF, sat=1.
  - SAT=0 → y=5, sat=1.
  - Also m=0xFFFF_FFFF, x=1, b=1: SAT=1 → y=0xFFFF_FFFF, sat=1; SAT=0 → y=0, sat=1.
- Busy collisions: wr during MULT → drop pulse, first result unchanged. cfg write of the active channel during MULT → current y uses the old m, the next sample uses the new m.
- Invalid channel: NCH=3, CHW=2, wr ch=3 → drop=1, no valid. cfg_wr cfg_ch=3 → no channel modified.
- Reset mid-op: assert rst at T0+10 → busy=0 and valid never pulses. m/b read back as 1/0: wr x=9 → y=9.
